// File: rtl/pwm_dec_pkg.sv
// Shared constants for the PWM drive-pair decoder: FSM encoding, default
// counter width and direction codes.
package pwm_dec_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HIGH    = 2'd1;
  localparam logic [1:0] ST_LOW     = 2'd2;
  localparam logic [1:0] ST_STOPPED = 2'd3;

  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for one asynchronous line, with a one-cycle
// delayed copy and single-cycle rise/fall strobes.
module sync_edge_det
  import pwm_dec_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic sync_d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      sync_d <= 1'b0;
    end else begin
      sr     <= {sr[SYNC_STAGES-2:0], din};
      sync_d <= sr[SYNC_STAGES-1];
    end
  end

  assign sync = sr[SYNC_STAGES-1];
  assign rise = sync & ~sync_d;
  assign fall = ~sync & sync_d;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers direction, period and high time from a two-wire motor drive
// pair, and flags stopped/stuck drives and both-lines-high faults.
module pwm_decoder
  import pwm_dec_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_a,
  input  logic             pwm_b,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             direction,
  output logic             moto_stop,
  output logic             stuck_high,
  output logic             fault,
  output logic             led
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic a_s, a_d, a_rise, a_fall;
  logic b_s, b_d, b_rise, b_fall;
  logic rise, fall, cnt_max;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt, hi_lat;
  logic dir_lat, bad, skip;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk(sys_clk), .rst_n(sys_rst_n), .din(pwm_a),
    .sync(a_s), .sync_d(a_d), .rise(a_rise), .fall(a_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk(sys_clk), .rst_n(sys_rst_n), .din(pwm_b),
    .sync(b_s), .sync_d(b_d), .rise(b_rise), .fall(b_fall)
  );

  // Edges of (a_s | b_s) built from per-line edges gated by the other line.
  assign rise    = (a_rise & ~b_d) | (b_rise & ~a_d);
  assign fall    = (a_fall & ~b_s) | (b_fall & ~a_s);
  assign led     = a_s | b_s;
  assign fault   = a_s & b_s;
  assign cnt_max = (cnt == MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt     <= '0;
      hi_lat  <= '0;
      dir_lat <= DIR_A;
      bad     <= 1'b0;
    end else begin
      if (rise)
        cnt <= CNT_W'(1);
      else if (!cnt_max)
        cnt <= cnt + 1'b1;
      if (fall)
        hi_lat <= cnt;
      if (rise && !fault)
        dir_lat <= b_s ? DIR_B : DIR_A;
      if (fault)
        bad <= 1'b1;
      else if (state == ST_LOW && rise)
        bad <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      meas_valid <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      direction  <= DIR_A;
      moto_stop  <= 1'b0;
      stuck_high <= 1'b0;
      skip       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (rise)
        skip <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise)
            state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (fall) begin
            state <= ST_LOW;
          end else if (cnt_max) begin
            state      <= ST_STOPPED;
            moto_stop  <= 1'b1;
            stuck_high <= 1'b1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state <= ST_HIGH;
            if (!bad && !skip) begin
              period     <= cnt;
              high_time  <= hi_lat;
              direction  <= dir_lat;
              meas_valid <= 1'b1;
            end
          end else if (cnt_max) begin
            state      <= ST_STOPPED;
            moto_stop  <= 1'b1;
            stuck_high <= 1'b0;
          end
        end
        ST_STOPPED: begin
          if (rise) begin
            state      <= ST_HIGH;
            moto_stop  <= 1'b0;
            stuck_high <= 1'b0;
          end else if (fall) begin
            // Release from stuck-high: the next rise closes a period that
            // started before the stall, so it must not be reported.
            state      <= ST_LOW;
            moto_stop  <= 1'b0;
            stuck_high <= 1'b0;
            skip       <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: directed pattern table, hand-written
// stall/fault/reset sequences, and randomized bursts against a timestamp model.
module tb_pwm_decoder;

  localparam int MAX_V = 255;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       pwm_a, pwm_b;
  logic       meas_valid;
  logic [7:0] period, high_time;
  logic       direction, moto_stop, stuck_high, fault, led;

  pwm_decoder #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pwm_a(pwm_a), .pwm_b(pwm_b),
    .meas_valid(meas_valid), .period(period), .high_time(high_time),
    .direction(direction), .moto_stop(moto_stop), .stuck_high(stuck_high),
    .fault(fault), .led(led)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model on input-cycle timestamps: r = last rise, f = last fall.
  typedef struct {
    logic mv;
    int   per;
    int   hi;
    logic dir;
    logic stop;
    logic stuck;
  } exp_t;

  exp_t m_out, r1, r2;
  logic c1_f, c1_l;
  logic m_have_rise, m_fall_seen, m_stopped, m_stuck, m_skip, m_bad;
  logic m_dirlat, m_prev_act;
  int   m_k, m_r, m_f;

  int   obs_mv, obs_per, obs_hi, obs_dir, obs_fault;

  function automatic int sat(input int x);
    return (x > MAX_V) ? MAX_V : x;
  endfunction

  task automatic model_reset();
    m_out = '{mv: 1'b0, per: 0, hi: 0, dir: 1'b0, stop: 1'b0, stuck: 1'b0};
    r1 = m_out;
    r2 = m_out;
    c1_f = 1'b0;
    c1_l = 1'b0;
    m_have_rise = 1'b0; m_fall_seen = 1'b0; m_stopped = 1'b0; m_stuck = 1'b0;
    m_skip = 1'b0; m_bad = 1'b0; m_dirlat = 1'b0; m_prev_act = 1'b0;
    m_k = 0; m_r = 0; m_f = 0;
  endtask

  task automatic model_cycle(input logic a, input logic b);
    logic act, rs, fl, flt, low_rise;
    act = a | b;
    rs  = act & ~m_prev_act;
    fl  = ~act & m_prev_act;
    flt = a & b;
    low_rise = 1'b0;
    m_out.mv = 1'b0;
    if (rs) begin
      low_rise = m_have_rise && m_fall_seen && !m_stopped;
      if (low_rise && !m_bad && !m_skip) begin
        m_out.mv  = 1'b1;
        m_out.per = sat(m_k - m_r);
        m_out.hi  = sat(m_f - m_r);
        m_out.dir = m_dirlat;
      end
      m_skip = 1'b0;
      m_stopped = 1'b0;
      m_stuck = 1'b0;
      if (!flt) m_dirlat = b;
      m_have_rise = 1'b1;
      m_r = m_k;
      m_fall_seen = 1'b0;
    end else if (fl) begin
      if (m_have_rise) begin
        m_fall_seen = 1'b1;
        m_f = m_k;
      end
      if (m_stopped) begin
        m_stopped = 1'b0;
        m_stuck = 1'b0;
        m_skip = 1'b1;
      end
    end else if (m_have_rise && !m_stopped && (m_k - m_r >= MAX_V)) begin
      m_stopped = 1'b1;
      m_stuck = !m_fall_seen;
    end
    if (flt) m_bad = 1'b1;
    else if (low_rise) m_bad = 1'b0;
    m_out.stop = m_stopped;
    m_out.stuck = m_stuck;
    m_prev_act = act;
    m_k++;
  endtask

  // Drive one input cycle at the negedge, then compare after the next posedge.
  task automatic step(input logic a, input logic b);
    exp_t nxt;
    logic nf, nl;
    pwm_a = a;
    pwm_b = b;
    model_cycle(a, b);
    nxt = m_out;
    nf = a & b;
    nl = a | b;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("meas_valid", meas_valid, r2.mv);
    chk("period", period, r2.per);
    chk("high_time", high_time, r2.hi);
    chk("direction", direction, r2.dir);
    chk("moto_stop", moto_stop, r2.stop);
    chk("stuck_high", stuck_high, r2.stuck);
    chk("fault", fault, c1_f);
    chk("led", led, c1_l);
    if (meas_valid) begin
      obs_mv++;
      obs_per = period;
      obs_hi = high_time;
      obs_dir = direction;
    end
    obs_fault += fault;
    r2 = r1;
    r1 = nxt;
    c1_f = nf;
    c1_l = nl;
  endtask

  task automatic run_110(input int reps);
    for (int i = 0; i < reps; i++) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
  endtask

  typedef struct {
    logic [15:0] a_pat;
    logic [15:0] b_pat;
    int          len;
    int          reps;
    int          exp_per;
    int          exp_hi;
    logic        exp_dir;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int mv0, f0;
    vecs[0] = '{16'h0003, 16'h0000, 3, 6, 3, 2, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 2, 6, 2, 1, 1'b1};
    vecs[2] = '{16'h000F, 16'h0000, 8, 5, 8, 4, 1'b0};
    vecs[3] = '{16'h0000, 16'h0001, 7, 5, 7, 1, 1'b1};
    vecs[4] = '{16'h0001, 16'h0000, 2, 6, 2, 1, 1'b0};
    vecs[5] = '{16'h0000, 16'h03FF, 12, 4, 12, 10, 1'b1};
    obs_mv = 0; obs_per = 0; obs_hi = 0; obs_dir = 0; obs_fault = 0;

    sys_rst_n = 1'b0;
    pwm_a = 1'b0;
    pwm_b = 1'b0;
    model_reset();
    #1;
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_period", period, 0);
    chk("rst_moto_stop", moto_stop, 0);
    chk("rst_led", led, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Directed pattern table
    for (int i = 0; i < 6; i++) begin
      mv0 = obs_mv;
      for (int r = 0; r < vecs[i].reps; r++)
        for (int j = 0; j < vecs[i].len; j++)
          step(vecs[i].a_pat[j], vecs[i].b_pat[j]);
      chk($sformatf("vec%0d_mv_count_ok", i), int'((obs_mv - mv0) >= vecs[i].reps - 2), 1);
      chk($sformatf("vec%0d_period", i), obs_per, vecs[i].exp_per);
      chk($sformatf("vec%0d_high_time", i), obs_hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_direction", i), obs_dir, int'(vecs[i].exp_dir));
    end

    // Stuck idle: timeout, then rise clears without a measurement
    run_110(3);
    repeat (300) step(1'b0, 1'b0);
    chk("idle_moto_stop", moto_stop, 1);
    chk("idle_stuck_high", stuck_high, 0);
    mv0 = obs_mv;
    run_110(1);
    chk("idle_restart_no_mv", obs_mv - mv0, 0);
    chk("idle_restart_clear", moto_stop, 0);
    run_110(1);
    chk("idle_next_mv", obs_mv - mv0, 1);
    chk("idle_next_period", obs_per, 3);
    chk("idle_next_high", obs_hi, 2);

    // Stuck active
    repeat (300) step(1'b1, 1'b0);
    chk("active_moto_stop", moto_stop, 1);
    chk("active_stuck_high", stuck_high, 1);
    repeat (5) step(1'b0, 1'b0);
    chk("active_release_stuck", stuck_high, 0);
    mv0 = obs_mv;
    run_110(1);
    chk("active_restart_no_mv", obs_mv - mv0, 0);
    run_110(1);
    chk("active_next_mv", obs_mv - mv0, 1);
    chk("active_next_period", obs_per, 3);

    // Single-cycle both-high glitch mid-period
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 8; j++) step(j < 4, 1'b0);
    f0 = obs_fault;
    for (int j = 0; j < 8; j++) step(j < 4, j == 2);
    mv0 = obs_mv;
    for (int j = 0; j < 8; j++) step(j < 4, 1'b0);
    chk("fault_suppressed_mv", obs_mv - mv0, 0);
    chk("fault_cycles", obs_fault - f0, 1);
    for (int j = 0; j < 8; j++) step(j < 4, 1'b0);
    chk("fault_recover_mv", obs_mv - mv0, 1);
    chk("fault_recover_period", obs_per, 8);
    chk("fault_recover_high", obs_hi, 4);
    chk("fault_recover_dir", obs_dir, 0);

    // Randomized bursts, including holds around the saturation point
    for (int n = 0; n < 80; n++) begin
      int unsigned line, hi, lo, kind, gpos;
      logic glitch;
      line = $urandom_range(0, 1);
      hi = $urandom_range(1, 10);
      lo = $urandom_range(1, 10);
      kind = $urandom_range(0, 19);
      if (kind == 0) lo = $urandom_range(250, 260);
      if (kind == 1) hi = $urandom_range(250, 260);
      glitch = ($urandom_range(0, 7) == 0);
      gpos = $urandom_range(0, hi - 1);
      for (int unsigned j = 0; j < hi; j++) begin
        if (line == 0) step(1'b1, glitch && (j == gpos));
        else           step(glitch && (j == gpos), 1'b1);
      end
      for (int unsigned j = 0; j < lo; j++) step(1'b0, 1'b0);
    end

    // Asynchronous reset while the drive is high
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 8; j++) step(j < 4, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_meas_valid", meas_valid, 0);
    chk("arst_period", period, 0);
    chk("arst_high_time", high_time, 0);
    chk("arst_direction", direction, 0);
    chk("arst_moto_stop", moto_stop, 0);
    chk("arst_stuck_high", stuck_high, 0);
    chk("arst_fault", fault, 0);
    chk("arst_led", led, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    mv0 = obs_mv;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("arst_first_rise_no_mv", obs_mv - mv0, 0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("arst_second_rise_mv", obs_mv - mv0, 1);
    chk("arst_second_period", obs_per, 4);
    chk("arst_second_high", obs_hi, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
Receive-side counterpart of the key-driven motor PWM generator. It samples a two-wire motor drive pair (A/B, one line pulsed, the other held low) and recovers the drive direction, PWM period and high time. It also flags stopped/stuck drives and illegal both-high conditions. It sits on the feedback/monitor path for the motor and is used for self-check and for driving a status LED.

Parameters:
CNT_W, 16, width of the period/high-time counters and outputs; the counter saturates at MAX = 2^CNT_W-1.
SYNC_STAGES, 2, flip-flop stages on each asynchronous input; minimum 2.

Ports:
sys_clk  input  1  system clock; all logic on the rising edge.
sys_rst_n  input  1  asynchronous active-low reset.
pwm_a  input  1  drive line A (forward), asynchronous to sys_clk.
pwm_b  input  1  drive line B (reverse), asynchronous to sys_clk.
meas_valid  output  1  one-cycle pulse; period/high_time/direction updated this cycle.
period  output  CNT_W  cycles between successive active rising edges.
high_time  output  CNT_W  cycles active was high within that period.
direction  output  1  0 = A was pulsing, 1 = B was pulsing (for the reported period).
moto_stop  output  1  level; no rising edge seen for MAX cycles.
stuck_high  output  1  level; valid with moto_stop; 1 = input stuck active (100% duty), 0 = stuck idle.
fault  output  1  level; high in every cycle where both synchronized lines are high.
led  output  1  synchronized active level, for debug.

Behaviour:
- Sync: pwm_a and pwm_b each pass through SYNC_STAGES flops, giving a_s and b_s. Then active = a_s | b_s, and active_d is active delayed one cycle. rise = active & ~active_d; fall = ~active & active_d.
- Latency: with SYNC_STAGES=2, an input rise is sampled at edge e0; the corresponding meas_valid is high in the cycle after edge e2.
- Counter cnt, saturating at MAX: on rise, cnt <= 1; otherwise cnt <= cnt+1 unless cnt == MAX.
- On fall: hi_lat <= cnt.
- On rise:
  - dir_lat <= b_s.
  - A rise with both lines high leaves dir_lat unchanged and sets bad.
- States: IDLE, HIGH, LOW, STOPPED. Reset state is IDLE.
  - IDLE: rise -> HIGH. No meas_valid (no previous edge).
  - HIGH: fall -> LOW. cnt == MAX with no fall -> STOPPED with stuck_high=1.
  - LOW, on rise -> HIGH, and:
    - if bad == 0: period <= cnt, high_time <= hi_lat, direction <= dir_lat (value latched at the previous rise), meas_valid <= 1.
    - in all cases: bad <= 0.
  - LOW: cnt == MAX with no rise -> STOPPED with stuck_high=0.
  - STOPPED: moto_stop=1. On rise -> HIGH, moto_stop <= 0, stuck_high <= 0, no meas_valid. If stuck high, a fall goes first to LOW, which clears moto_stop.
  - STOPPED: period/high_time are held at their last values.
- Simultaneous events: a rise in the same cycle as cnt == MAX counts as the rise, not a timeout.
- Fault: fault = a_s & b_s, combinational from the registered sync outputs. Any fault cycle sets sticky bad. bad suppresses the meas_valid at the next rise in LOW, and that rise clears it.
- Widths: period can reach MAX. high_time is always <= period for valid measurements.
- Reset (async, any time): all flops clear.
  - Outputs: meas_valid=0, period=0, high_time=0, direction=0, moto_stop=0, stuck_high=0, fault=0, led=0.
  - State returns to IDLE. The first rise after reset gives no meas_valid.

Decomposition:
- Package pwm_dec_pkg: state encoding (IDLE/HIGH/LOW/STOPPED), default CNT_W, and the DIR_A/DIR_B constants.
- Sub-module sync_edge_det: SYNC_STAGES synchronizer plus registered delay and rise/fall outputs. Instantiate it once per input line, and derive active/edges in the top.

Test Plan:
1. CNT_W=8, pwm_a repeating 1,1,0 (high 2, low 1) -> from the second period on, meas_valid every 3 cycles with period=3, high_time=2, direction=0, fault=0.
2. pwm_b repeating 1,0 (high 1, low 1) -> meas_valid every 2 cycles with period=2, high_time=1, direction=1.
3. CNT_W=8, pwm_a held low for 300 cycles after pulsing -> moto_stop=1, stuck_high=0 once cnt hits 255. The next rise clears moto_stop without meas_valid, and the following rise gives a valid measurement.
4. pwm_a held high for 300 cycles -> moto_stop=1, stuck_high=1. On release, LOW clears both; the next rise gives no meas_valid.
5. pwm_a pattern with pwm_b pulsed high for 1 cycle mid-period -> fault=1 for exactly 1 cycle, no meas_valid at the next rise, the following period reported normally.
6. sys_rst_n pulsed low mid-HIGH -> all outputs 0 immediately (async). The first rise after release gives no meas_valid; the second gives a correct period.
